// File: rtl/axi_lite_ram_slv.sv
// axi_lite_ram_slv: AXI4-Lite slave backed by a byte-writable RAM, one outstanding read and write.
// Define AXI_RAM_SLV_ERR_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module axi_lite_ram_slv #(
  parameter int DEPTH = 1024,
  parameter int AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] slv_axi_awaddr,
  input  logic [2:0]    slv_axi_awprot,
  input  logic          slv_axi_awvalid,
  output logic          slv_axi_awready,
  input  logic [31:0]   slv_axi_wdata,
  input  logic [3:0]    slv_axi_wstrb,
  input  logic          slv_axi_wvalid,
  output logic          slv_axi_wready,
  output logic [1:0]    slv_axi_bresp,
  output logic          slv_axi_bvalid,
  input  logic          slv_axi_bready,
  input  logic [AW-1:0] slv_axi_araddr,
  input  logic [2:0]    slv_axi_arprot,
  input  logic          slv_axi_arvalid,
  output logic          slv_axi_arready,
  output logic [31:0]   slv_axi_rdata,
  output logic [1:0]    slv_axi_rresp,
  output logic          slv_axi_rvalid,
  input  logic          slv_axi_rready
);
  localparam int IW = $clog2(DEPTH);
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;
  w_state_t r_wst;
  r_state_t r_rst;
  logic [31:0]   r_mem [DEPTH];
  logic          r_aw_got, r_w_got, r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [AW-1:0] r_awaddr;
  logic [31:0]   r_wdata, r_rdata;
  logic [3:0]    r_wstrb;
  logic [1:0]    r_bresp, r_rresp;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_aw_have, w_w_have, w_commit, w_wen, w_woor, w_roor;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_data, w_rdata;
  logic [3:0]    w_strb;
  logic [IW-1:0] w_widx, w_ridx;
  logic [1:0]    w_bresp, w_rresp;
  logic          w_unused;
  assign w_aw_hs   = slv_axi_awvalid & r_awready;
  assign w_w_hs    = slv_axi_wvalid & r_wready;
  assign w_ar_hs   = slv_axi_arvalid & r_arready;
  assign w_aw_have = r_aw_got | w_aw_hs;
  assign w_w_have  = r_w_got | w_w_hs;
  // a beat arriving this edge is used directly so same-cycle capture commits immediately
  assign w_addr    = r_aw_got ? r_awaddr : slv_axi_awaddr;
  assign w_data    = r_w_got ? r_wdata : slv_axi_wdata;
  assign w_strb    = r_w_got ? r_wstrb : slv_axi_wstrb;
  assign w_commit  = ~rst & (r_wst == W_IDLE) & w_aw_have & w_w_have;
  assign w_widx    = w_addr[IW+1:2];
  assign w_ridx    = slv_axi_araddr[IW+1:2];
  assign w_woor    = |w_addr[AW-1:IW+2];
  assign w_roor    = |slv_axi_araddr[AW-1:IW+2];
`ifdef AXI_RAM_SLV_ERR_EN
  assign w_wen     = w_commit & ~w_woor;
  assign w_bresp   = w_woor ? 2'b10 : 2'b00;
  assign w_rresp   = w_roor ? 2'b10 : 2'b00;
  assign w_rdata   = w_roor ? 32'h0 : r_mem[w_ridx];
`else
  assign w_wen     = w_commit;
  assign w_bresp   = 2'b00;
  assign w_rresp   = 2'b00;
  assign w_rdata   = r_mem[w_ridx];
`endif
  assign w_unused  = ^{slv_axi_awprot, slv_axi_arprot, w_addr, slv_axi_araddr, w_woor, w_roor};
  always_ff @(posedge clk)
    if (w_wen)
      for (int i = 0; i < 4; i++)
        if (w_strb[i]) r_mem[w_widx][8*i +: 8] <= w_data[8*i +: 8];
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wst     <= W_IDLE;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
    end else if (r_wst == W_IDLE) begin
      if (w_aw_hs) begin
        r_aw_got <= 1'b1;
        r_awaddr <= slv_axi_awaddr;
      end
      if (w_w_hs) begin
        r_w_got <= 1'b1;
        r_wdata <= slv_axi_wdata;
        r_wstrb <= slv_axi_wstrb;
      end
      if (w_aw_have & w_w_have) begin
        r_wst     <= W_RESP;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_bresp;
        r_awready <= 1'b0;
        r_wready  <= 1'b0;
      end else begin
        r_awready <= ~w_aw_have;
        r_wready  <= ~w_w_have;
      end
    end else if (slv_axi_bready) begin
      r_wst     <= W_IDLE;
      r_bvalid  <= 1'b0;
      r_aw_got  <= 1'b0;
      r_w_got   <= 1'b0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst     <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= 32'h0;
    end else if (r_rst == R_IDLE) begin
      if (w_ar_hs) begin
        r_rst     <= R_DATA;
        r_rdata   <= w_rdata;
        r_rresp   <= w_rresp;
        r_rvalid  <= 1'b1;
        r_arready <= 1'b0;
      end else begin
        r_arready <= 1'b1;
      end
    end else if (slv_axi_rready) begin
      r_rst     <= R_IDLE;
      r_rvalid  <= 1'b0;
      r_arready <= 1'b1;
    end
  end
  assign slv_axi_awready = r_awready;
  assign slv_axi_wready  = r_wready;
  assign slv_axi_bvalid  = r_bvalid;
  assign slv_axi_bresp   = r_bresp;
  assign slv_axi_arready = r_arready;
  assign slv_axi_rvalid  = r_rvalid;
  assign slv_axi_rresp   = r_rresp;
  assign slv_axi_rdata   = r_rdata;
endmodule

// File: tb/tb_axi_lite_ram_slv.sv
// tb_axi_lite_ram_slv: scoreboard bench for axi_lite_ram_slv with an array memory model.
// Honours AXI_RAM_SLV_ERR_EN the same way as the design.
module tb_axi_lite_ram_slv;
  localparam int DEPTH = 1024;
`ifdef AXI_RAM_SLV_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
  logic [3:0] wstrb = 0;
  logic awvalid = 0, wvalid = 0, arvalid = 0, awready, wready, arready, bvalid, rvalid;
  logic bready, rready, bready_d = 1, rready_d = 1, rbp_b = 1, rbp_r = 1, rand_bp = 0;
  logic [1:0] bresp, rresp;
  int checks = 0, errors = 0;
  logic [31:0] mdl [DEPTH];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];
  assign bready = rand_bp ? rbp_b : bready_d;
  assign rready = rand_bp ? rbp_r : rready_d;
  always #5 clk = ~clk;
  axi_lite_ram_slv #(.DEPTH(DEPTH), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .slv_axi_awaddr(awaddr), .slv_axi_awprot(3'b000), .slv_axi_awvalid(awvalid), .slv_axi_awready(awready),
    .slv_axi_wdata(wdata), .slv_axi_wstrb(wstrb), .slv_axi_wvalid(wvalid), .slv_axi_wready(wready),
    .slv_axi_bresp(bresp), .slv_axi_bvalid(bvalid), .slv_axi_bready(bready),
    .slv_axi_araddr(araddr), .slv_axi_arprot(3'b000), .slv_axi_arvalid(arvalid), .slv_axi_arready(arready),
    .slv_axi_rdata(rdata), .slv_axi_rresp(rresp), .slv_axi_rvalid(rvalid), .slv_axi_rready(rready)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic bit oor(input logic [31:0] a);
    return ERR && (a >= 32'(DEPTH * 4));
  endfunction
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction
  // Monitor: pops expectations on every response handshake and checks hold-while-stalled.
  logic       p_bv = 0, p_br = 0, p_rv = 0, p_rr = 0;
  logic [1:0] p_bresp;
  logic [33:0] p_r;
  always @(negedge clk) begin
    if (rst) begin
      p_bv = 0; p_rv = 0;
    end else begin
      if (p_bv && !p_br) chk("b_hold", {bvalid, bresp}, {1'b1, p_bresp});
      if (p_rv && !p_rr) chk("r_hold", {rvalid, rresp, rdata}, {1'b1, p_r});
      if (bvalid && bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", bresp, exp_b.pop_front());
      end
      if (rvalid && rready) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
        else chk("rresp_rdata", {rresp, rdata}, exp_r.pop_front());
      end
      p_bv = bvalid; p_br = bready; p_bresp = bresp;
      p_rv = rvalid; p_rr = rready; p_r = {rresp, rdata};
    end
  end
  initial forever begin
    @(posedge clk); #1;
    rbp_b = ($urandom_range(0, 2) != 0);
    rbp_r = ($urandom_range(0, 2) != 0);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic issue_write(input logic [31:0] a, d, input logic [3:0] s, input int dly_aw, dly_w);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int t = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && t >= dly_aw;
      wvalid  = !w_done && t >= dly_w;
      @(negedge clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(posedge clk); #1;
      aw_done |= aw_hs; w_done |= w_hs; t++;
      if (aw_hs && !w_done) chk("awready_drop", awready, 0);
      if (w_hs && !aw_done) chk("wready_drop", wready, 0);
      if (t > 60) begin
        chk("write_handshake_timeout", 1, 0);
        break;
      end
    end
    awvalid = 0; wvalid = 0;
    if (aw_done && w_done) begin
      chk("b_latency", bvalid, 1);
      chk("readys_after_commit", {awready, wready}, 0);
      if (!oor(a))
        for (int i = 0; i < 4; i++) if (s[i]) mdl[widx(a)][8*i +: 8] = d[8*i +: 8];
      exp_b.push_back(oor(a) ? 2'b10 : 2'b00);
    end
  endtask
  task automatic issue_read(input logic [31:0] a);
    bit hs;
    int t = 0;
    araddr = a; arvalid = 1;
    forever begin
      @(negedge clk);
      hs = arvalid && arready;
      if (hs) exp_r.push_back(oor(a) ? {2'b10, 32'h0} : {2'b00, mdl[widx(a)]});
      @(posedge clk); #1;
      if (hs) break;
      if (++t > 60) begin
        chk("read_handshake_timeout", 1, 0);
        break;
      end
    end
    arvalid = 0;
    if (hs) chk("r_latency", {rvalid, arready}, 2'b10);
  endtask
  task automatic wait_b;
    int t = 0;
    forever begin
      @(negedge clk);
      if (bvalid && bready) break;
      if (++t > 100) begin
        chk("b_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic wait_r;
    int t = 0;
    forever begin
      @(negedge clk);
      if (rvalid && rready) break;
      if (++t > 100) begin
        chk("r_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask
  task automatic write(input logic [31:0] a, d, input logic [3:0] s);
    issue_write(a, d, s, 0, 0);
    wait_b();
  endtask
  task automatic read(input logic [31:0] a);
    issue_read(a);
    wait_r();
  endtask
  task automatic reset_pulse(input int n);
    rst = 1; awvalid = 0; wvalid = 0; arvalid = 0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata}, 0);
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    chk("readys_after_reset", {awready, wready, arready}, 3'b111);
  endtask
  initial begin
    logic [31:0] a;
    bit hs;
    reset_pulse(3);
    for (int i = 0; i < 16; i++) write(i * 4, $urandom, 4'hF);
    write(32'h10, 32'hDEADBEEF, 4'hF);
    read(32'h10);
    write(32'h20, 32'h11223344, 4'hF);
    write(32'h20, 32'hAABBCCDD, 4'b0101);
    read(32'h20);
    write(32'h20, 32'hFFFFFFFF, 4'b0000);
    read(32'h20);
    bready_d = 0;
    issue_write(32'h24, 32'h13572468, 4'hF, 2, 0);
    awaddr = 32'h24; wdata = 32'hBAD0BAD0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("bp_bvalid", {bvalid, bresp}, {1'b1, 2'b00});
      chk("bp_readys", {awready, wready}, 0);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0; bready_d = 1;
    wait_b();
    read(32'h24);
    write(32'hC, 32'h1, 4'hF);
    fork
      issue_write(32'hC, 32'h2, 4'hF, 0, 0);
      issue_read(32'hC);
    join
    fork
      wait_b();
      wait_r();
    join
    read(32'hC);
    rready_d = 0;
    issue_read(32'h10);
    repeat (4) begin
      @(negedge clk);
      chk("r_backpressure", {rvalid, rdata}, {1'b1, mdl[4]});
    end
    @(posedge clk); #1;
    rready_d = 1;
    wait_r();
    write(32'h1000, 32'hCAFEF00D, 4'hF);
    read(32'h1000);
    read(32'h0);
    rand_bp = 1;
    repeat (300) begin
      a = $urandom_range(0, 15) * 4;
      if ($urandom_range(0, 3) == 0) a += $urandom_range(1, 7) << 12;
      if ($urandom_range(0, 1) == 0) begin
        issue_write(a, $urandom, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
        wait_b();
      end else read(a);
    end
    rand_bp = 0;
    repeat (2) @(posedge clk); #1;
    awaddr = 32'h20; awvalid = 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      hs = awvalid && awready;
      @(posedge clk); #1;
      if (hs) break;
    end
    awvalid = 0;
    chk("aw_only_captured", hs, 1);
    reset_pulse(1);
    wdata = 32'h55555555; wstrb = 4'hF; wvalid = 1;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      hs = wvalid && wready;
      @(posedge clk); #1;
      if (hs) break;
    end
    wvalid = 0;
    chk("w_only_captured", hs, 1);
    repeat (6) begin
      @(negedge clk);
      chk("no_commit_after_reset", bvalid, 0);
    end
    @(posedge clk); #1;
    reset_pulse(1);
    read(32'h20);
    chk("b_queue_empty", exp_b.size(), 0);
    chk("r_queue_empty", exp_r.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
